// File: rtl/spi_sclk_gen_if.sv
// Control/strobe bundle between the SPI register block (master) and the SCLK generator (slave).
interface spi_sclk_gen_if #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 5
);
    logic [DIV_W-1:0] div_i;
    logic             cpol_i;
    logic             cpha_i;
    logic [CNT_W-1:0] nbits_i;
    logic             start_i;
    logic             stop_i;
    logic             sclk_o;
    logic             busy_o;
    logic             sample_o;
    logic             shift_o;
    logic             done_o;

    modport master (
        output div_i, cpol_i, cpha_i, nbits_i, start_i, stop_i,
        input  sclk_o, busy_o, sample_o, shift_o, done_o
    );

    modport slave (
        input  div_i, cpol_i, cpha_i, nbits_i, start_i, stop_i,
        output sclk_o, busy_o, sample_o, shift_o, done_o
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: runtime half-period divisor, all CPOL/CPHA modes,
// 2*N SCLK edges per transfer with registered sample/shift/done strobes.
module spi_sclk_gen #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 5
) (
    input logic           PCLK,
    input logic           PRESET,
    spi_sclk_gen_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic             r_cpol, w_cpol_nxt;
    logic             r_cpha, w_cpha_nxt;
    logic [CNT_W-1:0] r_nbits, w_nbits_nxt;
    logic [DIV_W-1:0] r_hcnt, w_hcnt_nxt;
    logic [CNT_W:0]   r_edge, w_edge_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_sample, w_sample_nxt;
    logic             r_shift, w_shift_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W:0]   w_edge_inc;
    logic             w_lead;
    logic             w_last;

    assign w_edge_inc = r_edge + 1'b1;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state  <= StIdle;
            r_div    <= '0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_nbits  <= '0;
            r_hcnt   <= '0;
            r_edge   <= '0;
            r_sclk   <= 1'b0;
            r_sample <= 1'b0;
            r_shift  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_cpol   <= w_cpol_nxt;
            r_cpha   <= w_cpha_nxt;
            r_nbits  <= w_nbits_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_edge   <= w_edge_nxt;
            r_sclk   <= w_sclk_nxt;
            r_sample <= w_sample_nxt;
            r_shift  <= w_shift_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_cpol_nxt   = r_cpol;
        w_cpha_nxt   = r_cpha;
        w_nbits_nxt  = r_nbits;
        w_hcnt_nxt   = '0;
        w_edge_nxt   = '0;
        w_sclk_nxt   = r_sclk;
        w_sample_nxt = 1'b0;
        w_shift_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_lead       = w_edge_inc[0];
        w_last       = (w_edge_inc == {r_nbits, 1'b0});

        unique case (r_state)
            StIdle: begin
                w_sclk_nxt = bus.cpol_i;
                if (bus.start_i && (bus.nbits_i != '0)) begin
                    w_state_nxt = StRun;
                    w_div_nxt   = (bus.div_i == '0) ? DIV_W'(1) : bus.div_i;
                    w_cpol_nxt  = bus.cpol_i;
                    w_cpha_nxt  = bus.cpha_i;
                    w_nbits_nxt = bus.nbits_i;
                end
            end
            StRun: begin
                // Abort wins over an edge falling in the same cycle.
                if (bus.stop_i) begin
                    w_state_nxt = StIdle;
                    w_sclk_nxt  = r_cpol;
                end else if (r_hcnt == r_div - 1'b1) begin
                    w_sclk_nxt = ~r_sclk;
                    w_edge_nxt = w_edge_inc;
                    if (r_cpha) begin
                        w_shift_nxt  = w_lead;
                        w_sample_nxt = ~w_lead;
                    end else begin
                        w_sample_nxt = w_lead;
                        w_shift_nxt  = ~w_lead & ~w_last;
                    end
                    if (w_last) begin
                        w_state_nxt = StIdle;
                        w_done_nxt  = 1'b1;
                        w_sclk_nxt  = r_cpol;
                        w_edge_nxt  = '0;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                    w_edge_nxt = r_edge;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.sclk_o   = r_sclk;
    assign bus.busy_o   = (r_state == StRun);
    assign bus.sample_o = r_sample;
    assign bus.shift_o  = r_shift;
    assign bus.done_o   = r_done;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: stimulus queues expected edge strobes and level checks,
// a negedge monitor compares them against the DUT.
module tb_spi_sclk_gen;

    localparam int KBusy = 0;
    localparam int KSclk = 1;
    localparam int KAll  = 2;

    // exp = {sclk, busy, sample, shift, done}
    typedef struct {
        int         cyc;
        logic [4:0] exp;
    } ev_t;

    typedef struct {
        int         cyc;
        int         kind;
        logic [4:0] exp;
    } pt_t;

    logic PCLK;
    logic PRESET;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   end_chk = 0;
    bit   mon_done = 0;
    ev_t  sb[$];
    pt_t  pq[$];

    spi_sclk_gen_if #(.DIV_W(8), .CNT_W(5)) bus ();

    spi_sclk_gen #(.DIV_W(8), .CNT_W(5)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    // Expected strobe for every SCLK edge 1..klast of a transfer started at cycle t.
    function automatic void push_xfer(int t, int d, bit cp, bit ch, int n, int klast);
        ev_t e;
        bit  lead;
        bit  last;
        for (int k = 1; k <= klast; k++) begin
            lead  = (k % 2) == 1;
            last  = (k == 2 * n);
            e.cyc = t + k * d;
            e.exp = {cp ^ lead, ~last, ch ? ~lead : lead, ch ? lead : (~lead & ~last), last};
            sb.push_back(e);
        end
    endfunction

    function automatic void push_pt(int c, int kind, logic [4:0] exp);
        pt_t p;
        p.cyc  = c;
        p.kind = kind;
        p.exp  = exp;
        pq.push_back(p);
    endfunction

    initial begin : monitor
        logic [4:0] obs;
        logic [4:0] act;
        ev_t        ev;
        string      nm;
        forever begin
            @(negedge PCLK);
            obs = {bus.sclk_o, bus.busy_o, bus.sample_o, bus.shift_o, bus.done_o};
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                ev = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_strobe cycle %0d: got nothing, expected %b at cycle %0d",
                         cyc, ev.exp, ev.cyc);
            end
            if (obs[2:0] != 3'b000) begin
                vectors++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL spurious_strobe cycle %0d: got %b, expected no strobe", cyc, obs);
                end else begin
                    ev = sb.pop_front();
                    if (obs !== ev.exp) begin
                        miscompares++;
                        $display("FAIL edge_strobe cycle %0d: got %b, expected %b", cyc, obs, ev.exp);
                    end
                end
            end
            for (int i = pq.size() - 1; i >= 0; i--) begin
                if (pq[i].cyc <= cyc) begin
                    case (pq[i].kind)
                        KBusy:   begin act = {4'b0, obs[3]}; nm = "busy"; end
                        KSclk:   begin act = {4'b0, obs[4]}; nm = "sclk"; end
                        default: begin act = obs;            nm = "all_outputs"; end
                    endcase
                    vectors++;
                    if (act !== pq[i].exp) begin
                        miscompares++;
                        $display("FAIL %s cycle %0d: got %b, expected %b", nm, cyc, act, pq[i].exp);
                    end
                    pq.delete(i);
                end
            end
            if (end_chk && !mon_done) begin
                vectors++;
                if (sb.size() + pq.size() != 0) begin
                    miscompares++;
                    $display("FAIL leftover_expectations: got %0d pending, expected 0",
                             sb.size() + pq.size());
                end
                mon_done = 1;
            end
        end
    end

    // Idle cycles: sclk must follow the previous cycle's cpol_i, busy stays low.
    task automatic idle(input int m);
        for (int i = 0; i < m; i++) begin
            bus.cpol_i = 1'($urandom_range(0, 1));
            push_pt(cyc + 1, KSclk, {4'b0, bus.cpol_i});
            push_pt(cyc + 1, KBusy, 5'b0);
            @(negedge PCLK);
        end
    endtask

    // Called at a negedge; returns at the negedge where busy has just dropped.
    task automatic run_xfer(input int dv, input bit cp, input bit ch, input int n, input bit chaos);
        int d;
        int t;
        int total;
        d     = (dv == 0) ? 1 : dv;
        t     = cyc + 1;
        total = 2 * n * d;
        bus.div_i   = 8'(dv);
        bus.cpol_i  = cp;
        bus.cpha_i  = ch;
        bus.nbits_i = 5'(n);
        bus.start_i = 1'b1;
        push_xfer(t, d, cp, ch, n, 2 * n);
        push_pt(t, KSclk, {4'b0, cp});
        push_pt(t, KBusy, 5'b1);
        push_pt(t + total - 1, KBusy, 5'b1);
        push_pt(t + total, KBusy, 5'b0);
        for (int j = 0; j < total; j++) begin
            @(negedge PCLK);
            bus.start_i = 1'b0;
            if (chaos) begin
                bus.div_i   = 8'($urandom_range(0, 7));
                bus.cpol_i  = 1'($urandom_range(0, 1));
                bus.cpha_i  = 1'($urandom_range(0, 1));
                bus.nbits_i = 5'($urandom_range(1, 9));
                bus.start_i = 1'($urandom_range(0, 1));
            end
        end
        @(negedge PCLK);
        bus.start_i = 1'b0;
    endtask

    // Abort after edge kstop; start_i raised alongside stop_i must be ignored.
    task automatic stop_xfer(input int dv, input bit cp, input bit ch, input int n,
                             input int kstop);
        int d;
        int t;
        int ts;
        d  = (dv == 0) ? 1 : dv;
        t  = cyc + 1;
        ts = t + kstop * d;
        bus.div_i   = 8'(dv);
        bus.cpol_i  = cp;
        bus.cpha_i  = ch;
        bus.nbits_i = 5'(n);
        bus.start_i = 1'b1;
        push_xfer(t, d, cp, ch, n, kstop);
        push_pt(t, KBusy, 5'b1);
        @(negedge PCLK);
        bus.start_i = 1'b0;
        while (cyc < ts) @(negedge PCLK);
        bus.stop_i  = 1'b1;
        bus.start_i = 1'b1;
        push_pt(ts + 1, KSclk, {4'b0, cp});
        push_pt(ts + 1, KBusy, 5'b0);
        push_pt(ts + 2, KBusy, 5'b0);
        @(negedge PCLK);
        bus.stop_i  = 1'b0;
        bus.start_i = 1'b0;
        idle(3);
    endtask

    initial begin : stim
        int t;
        PRESET      = 1'b1;
        bus.div_i   = '0;
        bus.cpol_i  = 1'b1;
        bus.cpha_i  = 1'b0;
        bus.nbits_i = '0;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        push_pt(1, KAll, 5'b0);
        push_pt(2, KAll, 5'b0);
        push_pt(3, KAll, 5'b0);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        idle(3);

        // Mode 0, div 4, N 8
        run_xfer(4, 1'b0, 1'b0, 8, 1'b0);
        idle(2);
        // Mode 3, div 1, N 3
        run_xfer(1, 1'b1, 1'b1, 3, 1'b0);
        idle(1);
        // div 0 must match div 1
        run_xfer(0, 1'b1, 1'b1, 3, 1'b0);
        idle(1);
        // nbits 0: start ignored
        bus.nbits_i = '0;
        bus.div_i   = 8'd2;
        bus.start_i = 1'b1;
        for (int i = 1; i <= 4; i++) push_pt(cyc + i, KBusy, 5'b0);
        @(negedge PCLK);
        bus.start_i = 1'b0;
        idle(3);
        // Reconfiguration mid-transfer, then back-to-back with new values
        run_xfer(4, 1'b0, 1'b0, 5, 1'b1);
        run_xfer(2, 1'b1, 1'b0, 3, 1'b0);
        idle(1);
        // Abort cases
        stop_xfer(3, 1'b0, 1'b1, 4, 5);
        stop_xfer(1, 1'b1, 1'b0, 3, 2);

        // Asynchronous reset mid-transfer, sclk high and busy high at that point
        t = cyc + 1;
        bus.div_i   = 8'd4;
        bus.cpol_i  = 1'b1;
        bus.cpha_i  = 1'b0;
        bus.nbits_i = 5'd8;
        bus.start_i = 1'b1;
        push_xfer(t, 4, 1'b1, 1'b0, 8, 6);
        push_pt(t, KBusy, 5'b1);
        @(negedge PCLK);
        bus.start_i = 1'b0;
        while (cyc < t + 24) @(negedge PCLK);
        @(posedge PCLK);
        #2;
        PRESET = 1'b1;
        sb.delete();
        pq.delete();
        push_pt(cyc, KAll, 5'b0);
        push_pt(cyc + 1, KAll, 5'b0);
        @(posedge PCLK);
        #2;
        PRESET = 1'b0;
        @(negedge PCLK);
        idle(2);
        run_xfer(4, 1'b0, 1'b0, 8, 1'b0);
        idle(1);

        for (int r = 0; r < 16; r++) begin
            run_xfer($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 6), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        idle(4);
        @(posedge PCLK);
        end_chk = 1;
        for (int i = 0; i < 10 && !mon_done; i++) @(negedge PCLK);
        if (!mon_done) begin
            $display("FAIL monitor_timeout: got no final check, expected one within 10 cycles");
            $fatal(1, "monitor did not complete");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
